half_adder: RTL and testbench



---
 rtl/half_adder_pkg.sv | 13 +
 rtl/half_adder_cell.sv | 15 +
 rtl/half_adder.sv | 91 +++++++++
 tb/tb_half_adder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/half_adder_pkg.sv
// Shared constants for the registered half adder.
// Build option: HALF_ADDER_STATS_EN enables the carry-event counter.
package half_adder_pkg;

  localparam int unsigned HA_WIDTH_DEF = 1;
  localparam int unsigned HA_CNT_W_DEF = 16;

  // Largest value a counter of width w can hold; the counter stops here.
  function automatic logic [63:0] ha_cnt_max(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Single-lane combinational half adder (sum = a ^ b, carry = a & b).
module ha_cell (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  // One lane, no state.
  always_comb begin
    s_o = a_i ^ b_i;
    c_o = a_i & b_i;
  end

endmodule

// File: rtl/half_adder.sv
// Registered, lane-parallel half adder with valid qualifier.
// Build option: HALF_ADDER_STATS_EN adds a saturating counter of accepts
// with any carry set; otherwise carry_count is constant zero.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int unsigned WIDTH = HA_WIDTH_DEF,
  parameter int unsigned CNT_W = HA_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_count
);

  logic [WIDTH-1:0] lane_s;
  logic [WIDTH-1:0] lane_c;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] carry_q, carry_d;
  logic             valid_q, valid_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    ha_cell u_cell (
      .a_i (a[i]),
      .b_i (b[i]),
      .s_o (lane_s[i]),
      .c_o (lane_c[i])
    );
  end

  // Next state: capture lane results on accept, otherwise hold.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    valid_d = in_valid;
    if (in_valid) begin
      sum_d   = lane_s;
      carry_d = lane_c;
    end
  end

  // Output registers; reset wins over in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= '0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  assign sum       = sum_q;
  assign carry     = carry_q;
  assign out_valid = valid_q;

`ifdef HALF_ADDER_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ha_cnt_max(CNT_W));

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count accepts with any carry lane set, holding at the maximum.
  always_comb begin
    cnt_d = cnt_q;
    if (in_valid && (|lane_c) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register, updated on the same edge as sum/carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign carry_count = cnt_q;
`else
  assign carry_count = '0;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Directed self-checking bench for half_adder: a 1-lane instance with a
// 2-bit counter and a 4-lane instance with a 16-bit counter.
module tb_half_adder;

`ifdef HALF_ADDER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        v1 = 1'b0;
  logic [0:0]  a1 = '0, b1 = '0;
  logic [0:0]  s1, c1;
  logic        ov1;
  logic [1:0]  cnt1;

  logic        v4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [3:0]  s4, c4;
  logic        ov4;
  logic [15:0] cnt4;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(1), .CNT_W(2)) u_dut1 (
    .clk (clk), .rst (rst), .in_valid (v1), .a (a1), .b (b1),
    .sum (s1), .carry (c1), .out_valid (ov1), .carry_count (cnt1)
  );

  half_adder #(.WIDTH(4), .CNT_W(16)) u_dut4 (
    .clk (clk), .rst (rst), .in_valid (v4), .a (a4), .b (b4),
    .sum (s4), .carry (c4), .out_valid (ov4), .carry_count (cnt4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; v1 = 1'b0; v4 = 1'b0;
    step();
    @(negedge clk);
    rst = 1'b0;
    step();
    total_cnt++;
    if ({s1, c1, ov1} !== 3'b000) $display("FAIL reset_w1: got %b expected 000", {s1, c1, ov1});
    else pass_cnt++;
    total_cnt++;
    if (cnt1 !== 2'd0) $display("FAIL reset_cnt1: got %0d expected 0", cnt1);
    else pass_cnt++;
    total_cnt++;
    if ({s4, c4, ov4} !== 9'b0) $display("FAIL reset_w4: got %b expected 0", {s4, c4, ov4});
    else pass_cnt++;
    total_cnt++;
    if (cnt4 !== 16'd0) $display("FAIL reset_cnt4: got %0d expected 0", cnt4);
    else pass_cnt++;
  endtask

  // Back-to-back accepts of 00, 01, 10, 11.
  task automatic test_truth_table();
    logic [1:0] ab [4]     = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [1:0] exp_sc [4] = '{2'b00, 2'b10, 2'b10, 2'b01};
    logic [1:0] exp_cnt [4];
    exp_cnt = '{2'd0, 2'd0, 2'd0, STATS ? 2'd1 : 2'd0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v1 = 1'b1; a1 = ab[i][1]; b1 = ab[i][0];
      step();
      total_cnt++;
      if ({s1, c1} !== exp_sc[i]) $display("FAIL truth_%0d sum_carry: got %b expected %b", i, {s1, c1}, exp_sc[i]);
      else pass_cnt++;
      total_cnt++;
      if (ov1 !== 1'b1) $display("FAIL truth_%0d out_valid: got %b expected 1", i, ov1);
      else pass_cnt++;
      total_cnt++;
      if (cnt1 !== exp_cnt[i]) $display("FAIL truth_%0d count: got %0d expected %0d", i, cnt1, exp_cnt[i]);
      else pass_cnt++;
    end
  endtask

  // Idle cycle after 11: outputs hold, valid drops, inputs ignored.
  task automatic test_hold();
    @(negedge clk);
    v1 = 1'b0; a1 = 1'b1; b1 = 1'b0;
    step();
    total_cnt++;
    if ({s1, c1} !== 2'b01) $display("FAIL hold sum_carry: got %b expected 01", {s1, c1});
    else pass_cnt++;
    total_cnt++;
    if (ov1 !== 1'b0) $display("FAIL hold out_valid: got %b expected 0", ov1);
    else pass_cnt++;
    total_cnt++;
    if (cnt1 !== (STATS ? 2'd1 : 2'd0)) $display("FAIL hold count: got %0d expected %0d", cnt1, STATS ? 1 : 0);
    else pass_cnt++;
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    rst = 1'b1; v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    step();
    total_cnt++;
    if ({s1, c1, ov1, cnt1} !== 5'b0) $display("FAIL rst_prio: got %b expected 00000", {s1, c1, ov1, cnt1});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0; v1 = 1'b0;
    step();
    total_cnt++;
    if ({s1, c1, ov1, cnt1} !== 5'b0) $display("FAIL rst_release_idle: got %b expected 00000", {s1, c1, ov1, cnt1});
    else pass_cnt++;
  endtask

  task automatic test_multilane();
    logic [3:0]  va [3]    = '{4'b1100, 4'b0101, 4'b1111};
    logic [3:0]  vb [3]    = '{4'b1010, 4'b0011, 4'b0000};
    logic [3:0]  es [3]    = '{4'b0110, 4'b0110, 4'b1111};
    logic [3:0]  ec [3]    = '{4'b1000, 4'b0001, 4'b0000};
    logic [15:0] ecnt [3];
    ecnt = STATS ? '{16'd1, 16'd2, 16'd2} : '{16'd0, 16'd0, 16'd0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      v4 = 1'b1; a4 = va[i]; b4 = vb[i];
      step();
      total_cnt++;
      if (s4 !== es[i]) $display("FAIL lanes_%0d sum: got %b expected %b", i, s4, es[i]);
      else pass_cnt++;
      total_cnt++;
      if (c4 !== ec[i]) $display("FAIL lanes_%0d carry: got %b expected %b", i, c4, ec[i]);
      else pass_cnt++;
      total_cnt++;
      if (cnt4 !== ecnt[i]) $display("FAIL lanes_%0d count: got %0d expected %0d", i, cnt4, ecnt[i]);
      else pass_cnt++;
    end
    @(negedge clk);
    v4 = 1'b0;
    step();
    total_cnt++;
    if ({ov4, s4, c4} !== 9'b0_1111_0000) $display("FAIL lanes_idle: got %b expected 011110000", {ov4, s4, c4});
    else pass_cnt++;
  endtask

  // 2-bit counter: four carry accepts give 1, 2, 3, 3.
  task automatic test_saturation();
    logic [1:0] ecnt [4];
    ecnt = STATS ? '{2'd1, 2'd2, 2'd3, 2'd3} : '{2'd0, 2'd0, 2'd0, 2'd0};
    @(negedge clk);
    rst = 1'b1; v1 = 1'b0;
    step();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
      step();
      total_cnt++;
      if (cnt1 !== ecnt[i]) $display("FAIL sat_%0d count: got %0d expected %0d", i, cnt1, ecnt[i]);
      else pass_cnt++;
      total_cnt++;
      if ({ov1, s1, c1} !== 3'b101) $display("FAIL sat_%0d valid_sum_carry: got %b expected 101", i, {ov1, s1, c1});
      else pass_cnt++;
    end
    @(negedge clk);
    v1 = 1'b0;
    step();
    total_cnt++;
    if (cnt1 !== ecnt[3]) $display("FAIL sat_idle count: got %0d expected %0d", cnt1, ecnt[3]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_hold();
    test_reset_priority();
    test_multilane();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish by 20000");
    $fatal(1, "timeout");
  end

endmodule
